mem_arbiter: RTL

- Sequences and shares the single-ported main memory between the instruction cache (read-only line fills) and the data cache (line fills and write-backs).
- Each granted request is a burst of BURST_LEN word transfers to an aligned line.
- The block issues one mem_read/mem_write pulse per word, waits for the memory's registered ready, and steers data and strobes back to the granted requester.
- Sits between the cache top level and the main memory module.

---
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported main memory between I-cache line fills
// and D-cache line fills / write-backs. Each grant runs a BURST_LEN-beat burst
// to an aligned line: one strobe per beat, then a wait for the registered ready.
// Optional feature macro: MEM_ARB_RR_EN selects round-robin arbitration on ties.
// When it is undefined, D has fixed priority over I and no pointer exists.
module mem_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int ADDR_W    = 32,
    localparam int BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction cache port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_rvalid,
    output logic              i_done,
    // data cache port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_rvalid,
    output logic              d_done,
    // status
    output logic [BEAT_W-1:0] beat,
    output logic              busy,
    // main memory port
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    // Clearing the low bits aligns the base to a full line, so beats never
    // cross a line boundary.
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BURST_LEN * 4 - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic              owner_d;   // 1 = D-cache owns the burst, 0 = I-cache
    logic              we;        // latched direction of the current burst
    logic [ADDR_W-1:0] base;      // aligned line address of the current burst
    logic [31:0]       i_rdata_q;
    logic [31:0]       d_rdata_q;

    logic              grant_any;
    logic              grant_d;
    logic              grant_we;
    logic [ADDR_W-1:0] grant_base;
    logic [ADDR_W-1:0] next_addr;
    logic              rd_beat;

`ifdef MEM_ARB_RR_EN
    // 1 = I was granted last. Resets to "D last" so I wins the first tie.
    logic rr_last_i;

    // Round-robin pointer tracks the requester granted most recently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_last_i <= 1'b0;
        else if (state == IDLE && grant_any)
            rr_last_i <= ~grant_d;
    end
`endif

    // Arbitration and address of the burst that would start this cycle.
    always_comb begin
        grant_any = i_req | d_req;
`ifdef MEM_ARB_RR_EN
        grant_d   = d_req & (~i_req | rr_last_i);
`else
        grant_d   = d_req;
`endif
        grant_we   = grant_d & d_we;
        grant_base = (grant_d ? d_addr : i_addr) & LINE_MASK;
        next_addr  = base + ((ADDR_W'(beat) + ADDR_W'(1)) << 2);
    end

    // Burst sequencer: strobes, address and done pulses are all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner_d   <= 1'b1;
            we        <= 1'b0;
            base      <= '0;
            beat      <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner_d   <= grant_d;
                        we        <= grant_we;
                        base      <= grant_base;
                        beat      <= '0;
                        mem_addr  <= grant_base;
                        mem_read  <= ~grant_we;
                        mem_write <= grant_we;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Strobe lasts exactly this one cycle.
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // No timeout: a slow memory simply stretches the burst.
                    if (mem_ready) begin
                        if (beat == LAST_BEAT) begin
                            i_done <= ~owner_d;
                            d_done <= owner_d;
                            state  <= DONE;
                        end else begin
                            beat      <= beat + BEAT_W'(1);
                            mem_addr  <= next_addr;
                            mem_read  <= ~we;
                            mem_write <= we;
                            state     <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    i_done <= 1'b0;
                    d_done <= 1'b0;
                    beat   <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data is forwarded straight from memory in the ready cycle.
    always_comb begin
        rd_beat   = (state == WAIT) & mem_ready & ~we;
        i_rvalid  = rd_beat & ~owner_d;
        d_rvalid  = rd_beat & owner_d;
        i_rdata   = i_rvalid ? mem_rdata : i_rdata_q;
        d_rdata   = d_rvalid ? mem_rdata : d_rdata_q;
        mem_wdata = (state == ISSUE && we) ? d_wdata : 32'h0;
        busy      = (state != IDLE);
    end

    // Hold the last delivered word on each rdata output between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
        end else begin
            if (i_rvalid) i_rdata_q <= mem_rdata;
            if (d_rvalid) d_rdata_q <= mem_rdata;
        end
    end

endmodule
